// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole hit detection path.
package whack_pkg;

    localparam int unsigned NUM_MOLES          = 8;
    localparam int unsigned DEB_CYCLES_DEFAULT = 500000;

    typedef logic [NUM_MOLES-1:0] mole_mask_t;

    typedef enum logic [0:0] {
        WAIT_ROUND = 1'b0,
        ACTIVE     = 1'b1
    } hit_state_e;

    function automatic logic [3:0] popcount(input mole_mask_t m);
        logic [3:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_MOLES; i++) begin
            cnt = cnt + 4'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mole_hit_detector_sw_debounce.sv
// One switch: 2-flop synchronizer, stability counter and a one-cycle flip pulse
// asserted on the edge where a new level is accepted.
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic flip
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = sw_async;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        flip     = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_d = s2_q;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mole_hit_detector.sv
// Debounces the player switches and scores each lit mole at most once per round,
// emitting a registered one-cycle hit pulse with mask and popcount.
module mole_hit_detector
    import whack_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_MOLES-1:0] sw,
    input  logic [NUM_MOLES-1:0] mole_on,
    input  logic                 round_tick,
    output logic                 hit_valid,
    output logic [3:0]           hit_amt,
    output logic [NUM_MOLES-1:0] hit_mask,
    output logic                 armed
);

    mole_mask_t flip;
    mole_mask_t wk;
    mole_mask_t hit;

    hit_state_e state_q, state_d;
    mole_mask_t whacked_q, whacked_d;
    mole_mask_t hit_mask_q, hit_mask_d;
    logic [3:0] hit_amt_q, hit_amt_d;
    logic       hit_valid_q, hit_valid_d;

    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_async(sw[g]),
            .flip    (flip[g])
        );
    end

    // round_tick clears the scored set in the same cycle, so that cycle's flips
    // count toward the new round.
    always_comb begin
        state_d   = state_q;
        whacked_d = whacked_q;
        wk        = round_tick ? '0 : whacked_q;
        hit       = '0;
        case (state_q)
            WAIT_ROUND: begin
                whacked_d = '0;
                if (round_tick) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                hit       = flip & mole_on & ~wk;
                whacked_d = wk | hit;
            end
            default: state_d = WAIT_ROUND;
        endcase
        hit_mask_d  = hit;
        hit_amt_d   = popcount(hit);
        hit_valid_d = |hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_ROUND;
            whacked_q   <= '0;
            hit_mask_q  <= '0;
            hit_amt_q   <= '0;
            hit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            whacked_q   <= whacked_d;
            hit_mask_q  <= hit_mask_d;
            hit_amt_q   <= hit_amt_d;
            hit_valid_q <= hit_valid_d;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_amt   = hit_amt_q;
    assign hit_mask  = hit_mask_q;
    assign armed     = (state_q == ACTIVE);

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed plus random stimulus for mole_hit_detector, checked against a
// cycle-level behavioural model of the scoring rules.
module tb_mole_hit_detector;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] mole_on = '0;
    logic         round_tick = 1'b0;
    logic         hit_valid;
    logic [3:0]   hit_amt;
    logic [N-1:0] hit_mask;
    logic         armed;

    int total = 0;
    int bad   = 0;

    // model state: raw samples delayed two edges, accepted level, run of differing samples
    logic [N-1:0] m_d1, m_d2, m_level, m_scored;
    int           m_run [N];
    bit           m_active;
    logic         e_valid;
    logic [3:0]   e_amt;
    logic [N-1:0] e_mask;

    mole_hit_detector #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .mole_on   (mole_on),
        .round_tick(round_tick),
        .hit_valid (hit_valid),
        .hit_amt   (hit_amt),
        .hit_mask  (hit_mask),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_level = '0; m_scored = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_active = 0;
        e_valid = 1'b0; e_amt = '0; e_mask = '0;
    endtask

    // Called right after a rising edge; inputs still hold their pre-edge values.
    task automatic model_tick();
        logic [N-1:0] flips, hits;
        flips = '0;
        hits  = '0;
        for (int i = 0; i < N; i++) begin
            if (m_d2[i] != m_level[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEB) begin
                    flips[i]   = 1'b1;
                    m_level[i] = m_d2[i];
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = sw;
        if (m_active) begin
            if (round_tick) m_scored = '0;
            hits     = flips & mole_on & ~m_scored;
            m_scored = m_scored | hits;
        end else if (round_tick) begin
            m_active = 1;
        end
        e_mask  = hits;
        e_amt   = 4'($countones(hits));
        e_valid = |hits;
    endtask

    task automatic check_eq(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic check_model();
        check_eq("hit_valid", int'(hit_valid), int'(e_valid));
        check_eq("hit_amt",   int'(hit_amt),   int'(e_amt));
        check_eq("hit_mask",  int'(hit_mask),  int'(e_mask));
        check_eq("armed",     int'(armed),     int'(m_active));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        check_model();
    endtask

    // Runs up to maxc cycles, returning the cycle count at which hit_valid was seen (0 = never).
    task automatic wait_pulse(input int maxc, output int n);
        n = 0;
        for (int k = 1; k <= maxc; k++) begin
            cyc();
            if (hit_valid === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int k = 0; k < ncyc; k++) begin
            cyc();
            if (hit_valid === 1'b1) pulses++;
        end
    endtask

    task automatic tick_round();
        round_tick = 1'b1;
        cyc();
        round_tick = 1'b0;
    endtask

    initial begin
        int n, p;

        // 1: switches high through reset, no round yet
        sw = 8'hFF;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_pulses(20, p);
        check_eq("no_hit_before_round", p, 0);
        check_eq("armed_before_round", int'(armed), 0);
        tick_round();
        check_eq("armed_after_round", int'(armed), 1);
        count_pulses(3, p);
        check_eq("no_hit_after_arm", p, 0);

        // 2: single lit mole, latency and pulse contents
        mole_on = 8'h04;
        sw[2] = ~sw[2];
        wait_pulse(LAT + 4, n);
        check_eq("latency_t2", n, LAT);
        check_eq("amt_t2", int'(hit_amt), 1);
        check_eq("mask_t2", int'(hit_mask), 8'h04);
        cyc();
        check_eq("pulse_one_cycle", int'(hit_valid), 0);
        check_eq("mask_cleared", int'(hit_mask), 0);

        // 3: bounce then settle at original level
        for (int k = 0; k < 3; k++) begin
            sw[2] = ~sw[2];
            cyc();
        end
        sw[2] = ~sw[2];
        count_pulses(12, p);
        check_eq("bounce_no_hit", p, 0);

        // 4: already scored this round, then new round scores again
        sw[2] = ~sw[2];
        count_pulses(12, p);
        check_eq("rescore_blocked", p, 0);
        tick_round();
        sw[2] = ~sw[2];
        wait_pulse(LAT + 4, n);
        check_eq("latency_t4", n, LAT);
        check_eq("amt_t4", int'(hit_amt), 1);

        // 5: all switches flip together
        tick_round();
        mole_on = 8'hA5;
        sw = ~sw;
        wait_pulse(LAT + 4, n);
        check_eq("latency_t5", n, LAT);
        check_eq("amt_t5", int'(hit_amt), 4);
        check_eq("mask_t5", int'(hit_mask), 8'hA5);
        count_pulses(6, p);
        check_eq("single_pulse_t5", p, 0);

        // 6: reset in the middle of a debounce
        tick_round();
        mole_on = 8'hFF;
        sw[0] = ~sw[0];
        repeat (3) cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        check_eq("armed_in_reset", int'(armed), 0);
        check_eq("valid_in_reset", int'(hit_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_pulses(20, p);
        check_eq("no_hit_after_reset", p, 0);
        check_eq("armed_after_reset", int'(armed), 0);

        // Random phase against the model
        tick_round();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 4) == 0) sw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 20) == 0) sw = sw ^ 8'($urandom);
            if ($urandom_range(0, 7) == 0) mole_on = 8'($urandom);
            round_tick = ($urandom_range(0, 40) == 0);
            cyc();
        end
        round_tick = 1'b0;
        repeat (LAT + 2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
